// File: rtl/spawn_pkg.sv
// spawn_pkg: lane, length and interval constants shared by the spawn scheduler, display and scoring logic
package spawn_pkg;
  localparam int NUM_LANES = 10;
  localparam int LANE_W = 4;
  localparam int MAX_LEN = 4;
  localparam int LEN_W = 3;
  localparam int CNT_W = 24;
  localparam int BASE_INTERVAL = 2500000;
  localparam int MIN_INTERVAL = 500000;
  localparam int LEVEL_STEP = 100000;
  typedef enum logic [1:0] {IDLE, WAIT, PROBE, ISSUE} state_e;
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return l == '0 ? LEN_W'(1) : l > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : l;
  endfunction
endpackage

// File: rtl/target_spawn_scheduler_if.sv
// target_spawn_scheduler_if: spawn request handshake and lane-clear channel
interface target_spawn_scheduler_if;
  import spawn_pkg::*;
  logic spawn_valid;
  logic spawn_ready;
  logic [LANE_W-1:0] spawn_lane;
  logic [LEN_W-1:0] spawn_len;
  logic clear_valid;
  logic [LANE_W-1:0] clear_lane;
  modport master(output spawn_valid, spawn_lane, spawn_len, input spawn_ready, clear_valid, clear_lane);
  modport slave(input spawn_valid, spawn_lane, spawn_len, output spawn_ready, clear_valid, clear_lane);
endinterface

// File: rtl/spawn_interval_timer.sv
// spawn_interval_timer: level-dependent spawn interval countdown with pause and expiry flag
module spawn_interval_timer #(
  parameter int BASE_INTERVAL = spawn_pkg::BASE_INTERVAL,
  parameter int MIN_INTERVAL = spawn_pkg::MIN_INTERVAL,
  parameter int LEVEL_STEP = spawn_pkg::LEVEL_STEP
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] level,
  output logic       expire
);
  import spawn_pkg::*;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] red;
  logic [CNT_W-1:0] interval;
  // compare before subtracting so a high level never wraps below the floor
  assign red = 32'(level) * 32'(LEVEL_STEP);
  assign interval = (red + 32'(MIN_INTERVAL) >= 32'(BASE_INTERVAL)) ? CNT_W'(MIN_INTERVAL) : CNT_W'(32'(BASE_INTERVAL) - red);
  assign expire = en && cnt_q == CNT_W'(1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else if (load) cnt_q <= interval;
    else if (en && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
endmodule

// File: rtl/target_spawn_scheduler.sv
// target_spawn_scheduler: picks a free lane each interval and issues spawn requests over valid/ready
module target_spawn_scheduler #(
  parameter int BASE_INTERVAL = spawn_pkg::BASE_INTERVAL,
  parameter int MIN_INTERVAL = spawn_pkg::MIN_INTERVAL,
  parameter int LEVEL_STEP = spawn_pkg::LEVEL_STEP
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           pause,
  input  logic [3:0]                     level,
  input  logic [3:0]                     rand_lane,
  input  logic [2:0]                     rand_len,
  target_spawn_scheduler_if.master       sp,
  output logic [spawn_pkg::NUM_LANES-1:0] lane_busy,
  output logic                           active,
  output logic [15:0]                    skip_count
);
  import spawn_pkg::*;
  state_e state_q;
  logic [LANE_W-1:0] lane_q, probe_q;
  logic [LEN_W-1:0] len_q;
  logic valid_q;
  logic [15:0] skip_q;
  logic [NUM_LANES-1:0] busy_q, busy_d, set_m, clr_m;
  logic go, accept, skip, expire;
  assign go = state_q == IDLE && start && !stop;
  assign accept = state_q == ISSUE && valid_q && sp.spawn_ready && !stop;
  assign skip = state_q == PROBE && busy_q[lane_q] && probe_q == LANE_W'(NUM_LANES-1) && !stop;
  spawn_interval_timer #(.BASE_INTERVAL(BASE_INTERVAL), .MIN_INTERVAL(MIN_INTERVAL), .LEVEL_STEP(LEVEL_STEP)) u_timer (
    .clk(clk), .resetn(resetn), .load(go || accept || skip),
    .en(state_q == WAIT && !pause && !stop), .level(level), .expire(expire));
  // set after clear so an accept beats a same-cycle clear of its lane
  always_comb begin
    set_m = accept ? NUM_LANES'(1) << lane_q : '0;
    clr_m = (sp.clear_valid && sp.clear_lane < LANE_W'(NUM_LANES) && state_q != IDLE) ? NUM_LANES'(1) << sp.clear_lane : '0;
    busy_d = (stop || go) ? '0 : (busy_q & ~clr_m) | set_m;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      lane_q <= '0;
      probe_q <= '0;
      len_q <= '0;
      valid_q <= 1'b0;
      skip_q <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (stop) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end else case (state_q)
        IDLE: if (start) begin
          state_q <= WAIT;
          skip_q <= '0;
        end
        WAIT: if (expire) begin
          state_q <= PROBE;
          probe_q <= '0;
          lane_q <= rand_lane < LANE_W'(NUM_LANES) ? rand_lane : rand_lane - LANE_W'(NUM_LANES);
          len_q <= clamp_len(rand_len);
        end
        PROBE: if (!busy_q[lane_q]) begin
          state_q <= ISSUE;
          valid_q <= 1'b1;
        end else if (skip) begin
          state_q <= WAIT;
          skip_q <= skip_q + 16'(skip_q != 16'hFFFF);
        end else begin
          lane_q <= lane_q == LANE_W'(NUM_LANES-1) ? '0 : lane_q + LANE_W'(1);
          probe_q <= probe_q + LANE_W'(1);
        end
        ISSUE: if (sp.spawn_ready) begin
          state_q <= WAIT;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign sp.spawn_valid = valid_q;
  assign sp.spawn_lane = lane_q;
  assign sp.spawn_len = len_q;
  assign lane_busy = busy_q;
  assign active = state_q != IDLE;
  assign skip_count = skip_q;
endmodule
